// File: rtl/fetch_pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
// Holds the datapath width, the sequencer state encoding and the default boot/trap vectors.
// No logic; imported by fetch_pc_seq and fetch_redirect_buf.
package fetch_pc_seq_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h4000_0000;
  localparam logic [31:0] DEF_TRAP_PC  = 32'h4000_0100;

endpackage

// File: rtl/fetch_redirect_buf.sv
// One-entry pending-redirect buffer for redirects that arrive while imem is not ready.
// Latency: a parked target is presented the cycle after it is written; kill follows the entry.
// Backpressure: a newer redirect overwrites the entry; it drains on the first imem_ready cycle.
module fetch_redirect_buf
  import fetch_pc_seq_pkg::*;
#(
  parameter int unsigned XLEN = fetch_pc_seq_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            imem_ready,
  input  logic            clear,
  output logic            kill,
  output logic [XLEN-1:0] pend_tgt
);

  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  // Park a redirect that cannot be issued; drop the entry once a direct redirect or issue supersedes it.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (clear) begin
      pend_vld_d = 1'b0;
    end else if (redirect_valid && !imem_ready) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = redirect_target;
    end else if (redirect_valid || imem_ready) begin
      pend_vld_d = 1'b0;
    end
  end

  // Pending entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // While an entry is parked, whatever imem_addr currently holds is wrong-path.
  assign kill     = pend_vld_q;
  assign pend_tgt = pend_tgt_q;

endmodule

// File: rtl/fetch_pc_seq.sv
// Fetch-stage PC sequencer: drives imem_addr and the decode pc_d/pc_plus4D pair; FETCH_PERF_CNT_EN adds perf counters.
// Latency: address accepted in cycle N appears as pc_d with instr_valid_d in N+1; redirect lands on imem_addr in N+1.
// Backpressure: imem_ready=0 holds the address (parking redirects); stall_d=1 freezes decode outputs and re-issues.
module fetch_pc_seq
  import fetch_pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN     = fetch_pc_seq_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = DEF_TRAP_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall_d,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic            instr_valid_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_q, pc_d_nxt;
  logic            vld_q, vld_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] taddr_q, taddr_d;

  logic            misalign;
  logic            kill;
  logic [XLEN-1:0] pend_tgt;

  assign misalign = redirect_valid && redirect_target[1];

  fetch_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_ready      (imem_ready),
    .clear           (misalign),
    .kill            (kill),
    .pend_tgt        (pend_tgt)
  );

  // Next-state and datapath: redirect beats a parked redirect, which beats stall, which beats sequential advance.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    pc_d_nxt = pc_q;
    vld_d    = vld_q;
    trap_d   = 1'b0;
    taddr_d  = taddr_q;

    if (misalign) begin
      // Never put the bad target on the bus; go straight to the trap vector.
      state_d = ST_TRAP;
      req_d   = 1'b0;
      addr_d  = TRAP_PC;
      vld_d   = 1'b0;
      trap_d  = 1'b1;
      taddr_d = redirect_target;
    end else if (redirect_valid && !imem_ready) begin
      // Target parked in the buffer; current address is now wrong-path.
      state_d = (state_q == ST_FETCH || state_q == ST_WAIT) ? ST_WAIT : ST_FETCH;
      req_d   = 1'b1;
      vld_d   = 1'b0;
    end else if (redirect_valid) begin
      state_d = ST_FETCH;
      req_d   = 1'b1;
      addr_d  = redirect_target;
      vld_d   = 1'b0;
    end else if (kill && imem_ready) begin
      // Whatever was accepted this cycle is discarded in favour of the parked target.
      state_d = ST_FETCH;
      req_d   = 1'b1;
      addr_d  = pend_tgt;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT, ST_TRAP: begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end
        ST_FETCH, ST_WAIT: begin
          if (stall_d) begin
            state_d = imem_ready ? ST_FETCH : ST_WAIT;
          end else if (imem_ready) begin
            state_d  = ST_FETCH;
            pc_d_nxt = addr_q;
            addr_d   = addr_q + PC_STEP;
            vld_d    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC - PC_STEP;
      vld_q   <= 1'b0;
      trap_q  <= 1'b0;
      taddr_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d_nxt;
      vld_q   <= vld_d;
      trap_q  <= trap_d;
      taddr_q <= taddr_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign instr_valid_d = vld_q;
  assign pc_d          = pc_q;
  assign pc_plus4D     = pc_q + PC_STEP;
  assign misalign_trap = trap_q;
  assign trap_addr     = taddr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redir_q, perf_redir_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_redir_d = perf_redir_q;
    perf_stall_d = perf_stall_q;
    if (redirect_valid) begin
      perf_redir_d = perf_redir_q + 32'd1;
    end
    if (stall_d || state_q == ST_WAIT) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redir_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_redir_q <= perf_redir_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_redirects    = perf_redir_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Bench for fetch_pc_seq: directed scenarios followed by random traffic against a transaction-level model.
// Every cycle all outputs are compared 1 time unit after the rising edge.
// Inputs change only between edges.
module tb_fetch_pc_seq;

  localparam logic [31:0] RST_PC  = 32'h4000_0000;
  localparam logic [31:0] TRP_PC  = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall_d = 1'b0;
  logic        imem_ready = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4D;
  logic        misalign_trap;
  logic [31:0] trap_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stall_cycles;
`endif

  fetch_pc_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall_d         (stall_d),
    .imem_ready      (imem_ready),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .instr_valid_d   (instr_valid_d),
    .pc_d            (pc_d),
    .pc_plus4D       (pc_plus4D),
    .misalign_trap   (misalign_trap),
    .trap_addr       (trap_addr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model, expressed as "what the front end is asking for / what decode holds".
  bit          m_requesting;   // a fetch request is outstanding on the bus
  bit          m_starting;     // first cycle after reset or after a trap: request not yet raised
  logic [31:0] m_fetch;        // address on the bus
  logic [31:0] m_dec_pc;       // instruction held by decode
  bit          m_dec_vld;
  bit          m_trap;
  logic [31:0] m_trap_addr;
  logic [31:0] m_parked[$];    // at most one redirect waiting for the bus
  int unsigned m_redirs;

  task automatic model_reset();
    m_requesting = 0;
    m_starting   = 1;
    m_fetch      = RST_PC;
    m_dec_pc     = RST_PC - 32'd4;
    m_dec_vld    = 0;
    m_trap       = 0;
    m_trap_addr  = '0;
    m_parked.delete();
    m_redirs     = 0;
  endtask

  // Effect of one rising edge, given the inputs that were held before it.
  task automatic model_edge();
    m_trap = 0;
    if (redirect_valid) m_redirs++;
    if (redirect_valid && redirect_target[1]) begin
      m_trap = 1;
      m_trap_addr = redirect_target;
      m_fetch = TRP_PC;
      m_requesting = 0;
      m_starting = 1;
      m_dec_vld = 0;
      m_parked.delete();
    end else if (redirect_valid) begin
      m_dec_vld = 0;
      m_requesting = 1;
      m_starting = 0;
      if (imem_ready) begin
        m_fetch = redirect_target;
        m_parked.delete();
      end else begin
        m_parked.delete();
        m_parked.push_back(redirect_target);
      end
    end else if (m_parked.size() != 0 && imem_ready) begin
      m_fetch = m_parked.pop_front();
      m_dec_vld = 0;
      m_requesting = 1;
    end else if (m_starting) begin
      m_starting = 0;
      m_requesting = 1;
    end else if (stall_d) begin
      // decode frozen, same address re-issued
    end else if (m_requesting && imem_ready) begin
      m_dec_pc = m_fetch;
      m_dec_vld = 1;
      m_fetch = m_fetch + 32'd4;
    end else begin
      m_dec_vld = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'd0, imem_req}, {31'd0, m_requesting});
    check("imem_addr", imem_addr, m_fetch);
    check("instr_valid_d", {31'd0, instr_valid_d}, {31'd0, m_dec_vld});
    check("pc_d", pc_d, m_dec_pc);
    check("pc_plus4D", pc_plus4D, m_dec_pc + 32'd4);
    check("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
    check("trap_addr", trap_addr, m_trap_addr);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, RST_PC);
    check({tag, "_vld"}, {31'd0, instr_valid_d}, 32'd0);
    check({tag, "_pc"}, pc_d, RST_PC - 32'd4);
    check({tag, "_pc4"}, pc_plus4D, RST_PC);
    check({tag, "_trap"}, {31'd0, misalign_trap}, 32'd0);
    check({tag, "_taddr"}, trap_addr, 32'd0);
  endtask

  // One clock: apply inputs, take the edge, advance the model, compare.
  task automatic cyc(input bit rv, input logic [31:0] rt, input bit st, input bit rdy);
    redirect_valid  = rv;
    redirect_target = rt;
    stall_d         = st;
    imem_ready      = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Boot and sequential fetch.
    cyc(0, '0, 0, 1);
    check("seq0", imem_addr, 32'h4000_0000);
    cyc(0, '0, 0, 1);
    check("seq1", imem_addr, 32'h4000_0004);
    cyc(0, '0, 0, 1);
    check("seq2", imem_addr, 32'h4000_0008);
    cyc(0, '0, 0, 1);
    check("seq_pc", pc_d, 32'h4000_0008);

    // Decode stall holds everything.
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 1);
      check("stall_pc", pc_d, 32'h4000_0008);
      check("stall_addr", imem_addr, 32'h4000_000C);
      check("stall_vld", {31'd0, instr_valid_d}, 32'd1);
    end

    // Redirect wins over stall.
    cyc(1, 32'h4000_0200, 1, 1);
    check("redir_addr", imem_addr, 32'h4000_0200);
    check("redir_kill", {31'd0, instr_valid_d}, 32'd0);
    cyc(0, '0, 0, 1);
    check("redir_pc", pc_d, 32'h4000_0200);
    check("redir_vld", {31'd0, instr_valid_d}, 32'd1);

    // Two redirects while memory is busy: only the newer one is issued.
    cyc(0, '0, 0, 0);
    cyc(1, 32'h4000_0300, 0, 0);
    check("no300_a", {31'd0, imem_addr == 32'h4000_0300}, 32'd0);
    cyc(1, 32'h4000_0400, 0, 0);
    check("no300_b", {31'd0, imem_addr == 32'h4000_0300}, 32'd0);
    cyc(0, '0, 0, 0);
    check("no300_c", {31'd0, imem_addr == 32'h4000_0300}, 32'd0);
    cyc(0, '0, 0, 1);
    check("pend_issue", imem_addr, 32'h4000_0400);
    cyc(0, '0, 0, 1);
    check("pend_pc", pc_d, 32'h4000_0400);

    // Misaligned redirect.
    cyc(1, 32'h4000_0202, 0, 1);
    check("trap_pulse", {31'd0, misalign_trap}, 32'd1);
    check("trap_taddr", trap_addr, 32'h4000_0202);
    check("trap_vec", imem_addr, 32'h4000_0100);
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, 1);
      check("trap_once", {31'd0, misalign_trap}, 32'd0);
      check("no202", {31'd0, instr_valid_d && pc_d == 32'h4000_0202}, 32'd0);
      check("trap_hold", trap_addr, 32'h4000_0202);
    end

    // Address wrap.
    cyc(1, 32'hFFFF_FFFC, 0, 1);
    cyc(0, '0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_pc4", pc_plus4D, 32'h0000_0000);

    // Async reset while waiting with a parked redirect.
    cyc(0, '0, 0, 0);
    cyc(1, 32'h4000_0500, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    #3;
    rst_n = 1'b1;
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    check("post_rst", imem_addr, 32'h4000_0004);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) t = t | 32'd2;
      cyc($urandom_range(0, 99) < 12, t, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 70);
    end

`ifdef FETCH_PERF_CNT_EN
    check("perf_redirects", perf_redirects, m_redirs);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
